// File: rtl/mig_multiport_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mig_multiport_arbiter
// Purpose : Round-robin multi-port front end for the MIG app_* interface with
//           in-order read-return routing through a tag FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module mig_multiport_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_DEPTH  = 16,
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             ui_clk,
  input  logic                             sys_rst,
  input  logic                             init_calib_complete,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_wmask,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            app_addr,
  output logic [2:0]                       app_cmd,
  output logic                             app_en,
  input  logic                             app_rdy,
  output logic [DATA_WIDTH-1:0]            app_wdf_data,
  output logic [MASK_WIDTH-1:0]            app_wdf_mask,
  output logic                             app_wdf_wren,
  output logic                             app_wdf_end,
  input  logic                             app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]            app_rd_data,
  input  logic                             app_rd_data_valid,
  output logic                             busy,
  output logic                             err_unexpected_rd
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(TAG_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_rr_ptr;
  logic [PW-1:0]         r_port;
  logic                  r_is_wr;
  logic                  r_cmd_pend, r_data_pend;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_WIDTH-1:0] r_wmask;
  logic [PW-1:0]         r_tag_mem [TAG_DEPTH];
  logic [TW-1:0]         r_wptr, r_rptr;
  logic [TW:0]           r_level;
  logic [NUM_PORTS-1:0]  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_err;

  logic                  w_full, w_empty, w_found, w_grant, w_push, w_pop;
  logic [PW-1:0]         w_gnt_idx, w_head;
  int                    w_idx;

  assign w_full  = (r_level == (TW+1)'(TAG_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_head  = r_tag_mem[r_rptr];

  // Search from rr_ptr; reads are skipped while the tag FIFO cannot take their tag.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
      if (!w_found && req_valid[w_idx] && (req_we[w_idx] || !w_full)) begin
        w_found   = 1'b1;
        w_gnt_idx = PW'(w_idx);
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && init_calib_complete && w_found && !sys_rst;
  assign req_ready = w_grant ? (NUM_PORTS'(1) << w_gnt_idx) : '0;
  assign w_push    = r_cmd_pend && app_rdy && !r_is_wr;
  assign w_pop     = app_rd_data_valid && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: if ((!r_cmd_pend || app_rdy) && (!r_data_pend || app_wdf_rdy))
                 w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_port      <= '0;
      r_is_wr     <= 1'b0;
      r_cmd_pend  <= 1'b0;
      r_data_pend <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_port      <= w_gnt_idx;
        r_is_wr     <= req_we[w_gnt_idx];
        r_cmd_pend  <= 1'b1;
        r_data_pend <= req_we[w_gnt_idx];
        r_addr      <= req_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata     <= req_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        r_wmask     <= req_wmask[int'(w_gnt_idx)*MASK_WIDTH +: MASK_WIDTH];
        r_rr_ptr    <= (w_gnt_idx == PW'(NUM_PORTS-1)) ? '0 : w_gnt_idx + PW'(1);
      end else begin
        if (app_rdy)     r_cmd_pend  <= 1'b0;
        if (app_wdf_rdy) r_data_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (w_push) r_tag_mem[r_wptr] <= r_port;
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + TW'(1);
      if (w_pop)  r_rptr <= r_rptr + TW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (TW+1)'(1);
        2'b01:   r_level <= r_level - (TW+1)'(1);
        default: r_level <= r_level;
      endcase
      r_rsp_valid <= w_pop ? (NUM_PORTS'(1) << w_head) : '0;
      if (w_pop) r_rsp_data <= app_rd_data;
      if (app_rd_data_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign app_addr          = r_addr;
  assign app_cmd           = r_is_wr ? 3'b000 : 3'b001;
  assign app_en            = r_cmd_pend;
  assign app_wdf_data      = r_wdata;
  assign app_wdf_mask      = r_wmask;
  assign app_wdf_wren      = r_data_pend;
  assign app_wdf_end       = r_data_pend;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_data          = r_rsp_data;
  assign busy              = (r_state != S_IDLE) || !w_empty;
  assign err_unexpected_rd = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mig_multiport_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mig_multiport_arbiter
// Purpose : Directed self-checking bench for mig_multiport_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mig_multiport_arbiter;

  localparam int NP = 2;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;
  localparam int TD = 4;

  logic              ui_clk = 1'b0;
  logic              sys_rst;
  logic              init_calib_complete;
  logic [NP-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP*MW-1:0]  req_wmask;
  logic [DW-1:0]     rsp_data, app_wdf_data, app_rd_data;
  logic [AW-1:0]     app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [MW-1:0]     app_wdf_mask;
  logic              app_rd_data_valid, busy, err_unexpected_rd;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [DW-1:0] WDAT = {4{32'hDEADBEEF}};
  localparam logic [DW-1:0] D0   = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [DW-1:0] D1   = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [DW-1:0] D2   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  mig_multiport_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)
  ) dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .err_unexpected_rd(err_unexpected_rd)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  initial begin
    logic acc;
    int   en_cnt, wr_cnt;
    logic end_bad;

    sys_rst = 1'b1; init_calib_complete = 1'b0;
    req_valid = '0; req_we = '0;
    req_addr  = {28'h200, 28'h100};
    req_wdata = '0; req_wmask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0;

    repeat (3) @(negedge ui_clk);
    #1;
    chk("rst_app_en", app_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_unexpected_rd, 0);
    chk("rst_rsp_valid", rsp_valid, 0);

    @(negedge ui_clk);
    sys_rst   = 1'b0;
    req_valid = 2'b11;
    acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ui_clk); #1;
      acc = acc | (|req_ready) | app_en;
    end
    chk("calib_gate", acc, 0);

    @(negedge ui_clk);
    init_calib_complete = 1'b1;
    #1;
    chk("calib_first_p0", req_ready, 2'b01);

    // Four reads alternate ports; they also fill the 4-entry tag FIFO (tags 0,1,0,1).
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge ui_clk); #1;
        chk("rr_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(negedge ui_clk); #1;
      chk("rr_app_en", app_en, 1);
      chk("rr_addr", app_addr, (i % 2 == 0) ? 28'h100 : 28'h200);
      chk("rr_cmd", app_cmd, 3'b001);
    end

    @(negedge ui_clk); #1;
    chk("full_no_grant", req_ready, 2'b00);
    chk("full_busy", busy, 1);
    req_we = 2'b10;
    req_wdata[DW +: DW] = WDAT;
    req_wmask[MW +: MW] = '0;
    #1;
    chk("full_write_granted", req_ready, 2'b10);

    en_cnt = 0; wr_cnt = 0; end_bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ui_clk);
      app_wdf_rdy = (c == 3);
      #1;
      en_cnt += int'(app_en);
      wr_cnt += int'(app_wdf_wren);
      end_bad = end_bad | (app_wdf_end !== app_wdf_wren);
      if (c == 0) begin
        chk("wr_cmd", app_cmd, 3'b000);
        chk("wr_addr", app_addr, 28'h200);
        chk("wr_data", app_wdf_data, WDAT);
        chk("wr_mask", app_wdf_mask, 0);
      end
    end
    chk("wr_en_cycles", en_cnt, 1);
    chk("wr_wren_cycles", wr_cnt, 4);
    chk("wr_end_eq_wren", end_bad, 0);

    @(negedge ui_clk);
    app_wdf_rdy = 1'b0;
    req_we = 2'b00;
    req_valid = 2'b01;
    app_rd_data_valid = 1'b1; app_rd_data = D0;
    #1;
    chk("wr_done_wren", app_wdf_wren, 0);
    chk("full_still_blocked", req_ready, 2'b00);

    @(negedge ui_clk);
    app_rd_data = D1;
    #1;
    chk("rsp0_valid", rsp_valid, 2'b01);
    chk("rsp0_data", rsp_data, D0);
    chk("read_after_pop", req_ready, 2'b01);

    @(negedge ui_clk);
    req_valid = 2'b00;
    app_rd_data = D2;
    #1;
    chk("rsp1_valid", rsp_valid, 2'b10);
    chk("rsp1_data", rsp_data, D1);
    chk("reissue_addr", app_addr, 28'h100);
    chk("reissue_en", app_en, 1);

    @(negedge ui_clk);
    app_rd_data_valid = 1'b0; app_rd_data = '0;
    #1;
    chk("rsp2_valid", rsp_valid, 2'b01);
    chk("rsp2_data", rsp_data, D2);

    @(negedge ui_clk); #1;
    chk("rsp_idle_valid", rsp_valid, 2'b00);
    chk("rsp_hold_data", rsp_data, D2);

    // Stall a write in ISSUE, then reset asynchronously mid-cycle.
    req_valid = 2'b01; req_we = 2'b01;
    app_rdy = 1'b0;
    @(negedge ui_clk);
    req_valid = 2'b00;
    #1;
    chk("stall_app_en", app_en, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_app_en", app_en, 0);
    chk("arst_wren", app_wdf_wren, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", app_addr, 0);
    chk("arst_rsp_data", rsp_data, 0);

    @(negedge ui_clk);
    sys_rst = 1'b0; app_rdy = 1'b1;
    @(negedge ui_clk);
    app_rd_data_valid = 1'b1; app_rd_data = D1;
    @(negedge ui_clk);
    app_rd_data_valid = 1'b0;
    #1;
    chk("err_set", err_unexpected_rd, 1);
    chk("err_no_rsp", rsp_valid, 2'b00);
    repeat (3) @(negedge ui_clk);
    #1;
    chk("err_sticky", err_unexpected_rd, 1);
    chk("post_rst_no_cmd", app_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
